core_lsu: RTL

- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU-computed effective address plus store data and width/sign code from EX.
- Drives a single-outstanding request/grant/response data-memory bus, aligns byte lanes, sign/zero-extends load data, and presents a one-cycle writeback pulse.
- Raises misaligned, illegal-width and bus-timeout faults without issuing a bus request for the first two.

---
 rtl/core_lsu.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - load/store unit: request/grant/response data bus, lane alignment, load extension, faults
module core_lsu #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        we_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    input  logic        flush_in,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [3:0]  mem_be_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_gnt_in,
    input  logic        mem_rvalid_in,
    input  logic [31:0] mem_rdata_in,
    output logic        wb_valid_out,
    output logic [4:0]  wb_rd_out,
    output logic [31:0] wb_data_out,
    output logic        fault_out,
    output logic [1:0]  fault_cause_out,
    output logic [31:0] fault_addr_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            kill;
    logic            op_we;
    logic [2:0]      op_f3;
    logic [31:0]     op_addr;
    logic [4:0]      op_rd;

    logic            accept;
    logic            illegal;
    logic            misaligned;
    logic [3:0]      be_n;
    logic [31:0]     wdata_n;
    logic [31:0]     shifted;
    logic [31:0]     ld_data;
    logic            to_hit;

    assign req_ready_out = (state == IDLE);
    assign accept        = req_valid_in && (state == IDLE) && !flush_in;
    assign to_hit        = TO_EN && (to_cnt == TO_LAST);

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_n       = 4'hF;
        wdata_n    = 32'h0;
        if (we_in)
            illegal = funct3_in[2] || (funct3_in[1:0] == 2'b11);
        else
            illegal = (funct3_in[1:0] == 2'b11) || (funct3_in[2:1] == 2'b11);
        misaligned = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                     ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
        if (we_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << addr_in[1:0];
                    wdata_n = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    be_n    = addr_in[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{wdata_in[15:0]}};
                end
                default: begin
                    be_n    = 4'hF;
                    wdata_n = wdata_in;
                end
            endcase
        end
    end

    always_comb begin
        shifted = mem_rdata_in >> {op_addr[1:0], 3'b000};
        case (op_f3)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            to_cnt          <= '0;
            kill            <= 1'b0;
            op_we           <= 1'b0;
            op_f3           <= 3'b000;
            op_addr         <= 32'h0;
            op_rd           <= 5'd0;
            mem_req_out     <= 1'b0;
            mem_we_out      <= 1'b0;
            mem_addr_out    <= 32'h0;
            mem_be_out      <= 4'h0;
            mem_wdata_out   <= 32'h0;
            wb_valid_out    <= 1'b0;
            wb_rd_out       <= 5'd0;
            wb_data_out     <= 32'h0;
            fault_out       <= 1'b0;
            fault_cause_out <= 2'b00;
            fault_addr_out  <= 32'h0;
        end else begin
            wb_valid_out    <= 1'b0;
            wb_rd_out       <= 5'd0;
            wb_data_out     <= 32'h0;
            fault_out       <= 1'b0;
            fault_cause_out <= 2'b00;
            fault_addr_out  <= 32'h0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal || misaligned) begin
                            fault_out       <= 1'b1;
                            fault_cause_out <= illegal ? 2'b01 : 2'b00;
                            fault_addr_out  <= addr_in;
                        end else begin
                            state         <= REQ;
                            to_cnt        <= '0;
                            kill          <= 1'b0;
                            op_we         <= we_in;
                            op_f3         <= funct3_in;
                            op_addr       <= addr_in;
                            op_rd         <= rd_in;
                            mem_req_out   <= 1'b1;
                            mem_we_out    <= we_in;
                            mem_addr_out  <= {addr_in[31:2], 2'b00};
                            mem_be_out    <= be_n;
                            mem_wdata_out <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    if (flush_in && !op_we)
                        kill <= 1'b1;
                    // A grant arriving on the limit cycle still wins over the timeout.
                    if (mem_gnt_in || to_hit) begin
                        mem_req_out   <= 1'b0;
                        mem_we_out    <= 1'b0;
                        mem_addr_out  <= 32'h0;
                        mem_be_out    <= 4'h0;
                        mem_wdata_out <= 32'h0;
                        to_cnt        <= '0;
                        if (mem_gnt_in) begin
                            state <= op_we ? IDLE : WAIT;
                        end else begin
                            state           <= IDLE;
                            fault_out       <= 1'b1;
                            fault_cause_out <= 2'b10;
                            fault_addr_out  <= op_addr;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (flush_in)
                        kill <= 1'b1;
                    if (mem_rvalid_in) begin
                        state <= IDLE;
                        if (!(kill || flush_in)) begin
                            wb_valid_out <= 1'b1;
                            wb_rd_out    <= op_rd;
                            wb_data_out  <= ld_data;
                        end
                    end else if (to_hit) begin
                        state           <= IDLE;
                        fault_out       <= 1'b1;
                        fault_cause_out <= 2'b10;
                        fault_addr_out  <= op_addr;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
